// File: rtl/pft_loader.sv
// PFT write-side loader: streams feature vectors round-robin into the PFT banks.
// Optional PFT_LOADER_CNT_EN adds the fill_cnt output.
module pft_loader #(
    parameter int PFT_addr_width = 5,
    parameter int PFT_data_width = 8,
    parameter int PE_COL         = 16,
    parameter int PFT_bank       = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [PFT_addr_width-1:0]        base_addr,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PFT_data_width*PE_COL-1:0] in_data,
    input  logic                             in_last,
    output logic [PFT_bank-1:0]              write,
    output logic [PFT_addr_width-1:0]        PFT_waddr,
    output logic [PFT_data_width*PE_COL-1:0] din,
    output logic [PFT_bank-1:0]              valid,
    output logic                             done,
`ifdef PFT_LOADER_CNT_EN
    output logic [$clog2(PFT_bank):0]        fill_cnt,
`endif
    input  logic                             grp_release
);

    localparam int DW = PFT_data_width * PE_COL;
    localparam int PW = $clog2(PFT_bank);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t                    state, state_n;
    logic [PW-1:0]             bank_ptr, bank_ptr_n;
    logic                      in_ready_n, done_n;
    logic [PFT_bank-1:0]       write_n, valid_n, onehot;
    logic [PFT_addr_width-1:0] waddr_n;
    logic [DW-1:0]             din_n;
    logic                      xfer, full;
`ifdef PFT_LOADER_CNT_EN
    logic [PW:0]               cnt_n;
`endif

    assign xfer   = in_valid & in_ready;
    assign full   = (bank_ptr == PW'(PFT_bank - 1));
    assign onehot = {{(PFT_bank-1){1'b0}}, 1'b1} << bank_ptr;

    always_comb begin
        state_n    = state;
        bank_ptr_n = bank_ptr;
        write_n    = '0;
        din_n      = din;
        valid_n    = valid;
        waddr_n    = PFT_waddr;
        done_n     = done;
`ifdef PFT_LOADER_CNT_EN
        cnt_n      = fill_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n    = FILL;
                    waddr_n    = base_addr;
                    bank_ptr_n = '0;
                    valid_n    = '0;
`ifdef PFT_LOADER_CNT_EN
                    cnt_n      = '0;
`endif
                end
            end
            FILL: begin
                if (xfer) begin
                    write_n    = onehot;
                    din_n      = in_data;
                    valid_n    = valid | onehot;
                    bank_ptr_n = bank_ptr + PW'(1);
`ifdef PFT_LOADER_CNT_EN
                    cnt_n      = fill_cnt + (PW+1)'(1);
`endif
                    // the last bank always closes the group; the pointer never wraps
                    if (in_last || full)
                        state_n = HOLD;
                end
            end
            HOLD: begin
                done_n = 1'b1;
                if (grp_release) begin
                    state_n    = IDLE;
                    done_n     = 1'b0;
                    valid_n    = '0;
                    bank_ptr_n = '0;
`ifdef PFT_LOADER_CNT_EN
                    cnt_n      = '0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        in_ready_n = (state_n == FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bank_ptr  <= '0;
            in_ready  <= 1'b0;
            write     <= '0;
            PFT_waddr <= '0;
            din       <= '0;
            valid     <= '0;
            done      <= 1'b0;
`ifdef PFT_LOADER_CNT_EN
            fill_cnt  <= '0;
`endif
        end else begin
            state     <= state_n;
            bank_ptr  <= bank_ptr_n;
            in_ready  <= in_ready_n;
            write     <= write_n;
            PFT_waddr <= waddr_n;
            din       <= din_n;
            valid     <= valid_n;
            done      <= done_n;
`ifdef PFT_LOADER_CNT_EN
            fill_cnt  <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_pft_loader.sv
// Directed self-checking bench for pft_loader.
module tb_pft_loader;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [4:0]    base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic          in_last;
    logic [31:0]   write;
    logic [4:0]    PFT_waddr;
    logic [127:0]  din;
    logic [31:0]   valid;
    logic          done;
    logic          grp_release;
`ifdef PFT_LOADER_CNT_EN
    logic [5:0]    fill_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pft_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .write(write), .PFT_waddr(PFT_waddr),
        .din(din), .valid(valid), .done(done),
`ifdef PFT_LOADER_CNT_EN
        .fill_cnt(fill_cnt),
`endif
        .grp_release(grp_release)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    localparam logic [127:0] DA = {16{8'hA1}};
    localparam logic [127:0] DB = {16{8'hB2}};
    localparam logic [127:0] DC = {16{8'hC3}};
    localparam logic [127:0] DX = {16{8'h5A}};
    localparam logic [127:0] DY = {16{8'h3C}};

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; grp_release = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_write", write, 0);
        chk("rst_waddr", PFT_waddr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // test 1: three vectors, last on C
        start = 1'b1; base_addr = 5'd5;
        tick();
        start = 1'b0;
        chk("t1_ready", in_ready, 1);
        chk("t1_waddr", PFT_waddr, 5);
        in_valid = 1'b1; in_data = DA;
        tick();
        chk("t1_wA", write, 32'h1);
        chk("t1_dA", din, DA);
        in_data = DB;
        tick();
        chk("t1_wB", write, 32'h2);
        in_data = DC; in_last = 1'b1;
        tick();
        in_last = 1'b0;
        chk("t1_wC", write, 32'h4);
        chk("t1_dC", din, DC);
        chk("t1_valid", valid, 32'h7);
        chk("t1_ready_drop", in_ready, 0);
        chk("t1_done_early", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_w_hold", write, 0);
        chk("t1_ready_hold", in_ready, 0);
`ifdef PFT_LOADER_CNT_EN
        chk("t1_cnt", fill_cnt, 3);
`endif
        in_valid = 1'b0;
        grp_release = 1'b1;
        tick();
        grp_release = 1'b0;
        chk("t1_rel_done", done, 0);
        chk("t1_rel_valid", valid, 0);
        chk("t1_rel_ready", in_ready, 0);
`ifdef PFT_LOADER_CNT_EN
        chk("t1_rel_cnt", fill_cnt, 0);
`endif

        // test 2: full group without in_last
        start = 1'b1; base_addr = 5'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_data = 128'(i + 1);
            tick();
            if (i == 0) chk("t2_w0", write, 32'h1);
            if (i == 15) chk("t2_v15", valid, 32'h0000_FFFF);
        end
        chk("t2_w31", write, 32'h8000_0000);
        chk("t2_d31", din, 128'd32);
        chk("t2_valid", valid, 32'hFFFF_FFFF);
        chk("t2_ready", in_ready, 0);
        tick();
        chk("t2_no33", write, 0);
        chk("t2_done", done, 1);
        chk("t2_valid_held", valid, 32'hFFFF_FFFF);
`ifdef PFT_LOADER_CNT_EN
        chk("t2_cnt", fill_cnt, 32);
`endif
        in_valid = 1'b0;

        // test 4: start and release together in HOLD
        start = 1'b1; base_addr = 5'd9; grp_release = 1'b1;
        tick();
        grp_release = 1'b0;
        chk("t4_done", done, 0);
        chk("t4_valid", valid, 0);
        chk("t4_ready", in_ready, 0);
        chk("t4_waddr_kept", PFT_waddr, 2);
        tick();
        start = 1'b0;
        chk("t4_waddr_new", PFT_waddr, 9);
        chk("t4_fill", in_ready, 1);

        // test 3: bubbles
        in_valid = 1'b1; in_data = DX;
        tick();
        chk("t3_wX", write, 32'h1);
        chk("t3_dX", din, DX);
        in_valid = 1'b0; in_last = 1'b1;
        tick();
        in_last = 1'b0;
        chk("t3_bubble", write, 0);
        chk("t3_last_ign", in_ready, 1);
        in_valid = 1'b1; in_data = DY;
        tick();
        chk("t3_wY", write, 32'h2);
        chk("t3_dY", din, DY);
        chk("t3_valid", valid, 32'h3);
        in_valid = 1'b0;
        tick();
        chk("t3_bubble2", write, 0);

        // test 5: async reset mid-group after 2 writes
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_ready", in_ready, 0);
        chk("t5_valid", valid, 0);
        chk("t5_waddr", PFT_waddr, 0);
        chk("t5_din", din, 0);
        chk("t5_done", done, 0);
        #3;
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = DA;
        tick();
        tick();
        chk("t5_idle_ready", in_ready, 0);
        chk("t5_idle_write", write, 0);
        chk("t5_idle_valid", valid, 0);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pft_loader.md
Name: pft_loader

Overview:
- Upstream write-side controller for the point feature table (PFT) bank array.
- Accepts a stream of PE_COL-wide feature vectors over a valid/ready handshake and writes each vector into the next PFT bank, round-robin from bank 0, at one group address.
- Builds the per-bank valid mask that the PFT consumes, then holds the filled group until the downstream reader releases it.

Parameters:
PFT_addr_width, 5, width of the per-bank address.
PFT_data_width, 8, bits per feature element.
PE_COL, 16, feature elements per vector.
PFT_bank, 32, number of banks, which is also the maximum vectors per group.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  pulse; opens a new group.
base_addr  input  PFT_addr_width  group address, latched on an accepted start.
in_valid  input  1  input vector valid.
in_ready  output  1  loader can accept a vector.
in_data  input  PFT_data_width*PE_COL  feature vector.
in_last  input  1  final vector of the group; qualified by the handshake.
write  output  PFT_bank  one-hot bank write strobe.
PFT_waddr  output  PFT_addr_width  write address, common to all banks.
din  output  PFT_data_width*PE_COL  write data.
valid  output  PFT_bank  mask of banks written in the current group.
done  output  1  group complete; the valid mask is stable.
release  input  1  downstream has finished reading the group.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, in_ready=0, write=0, PFT_waddr=0, din=0, valid=0, done=0, bank_ptr=0. Asserting reset mid-group discards the group and nothing resumes.
- All outputs are registered.
- State IDLE:
  - in_ready=0.
  - start=1 → FILL next cycle; latch base_addr into PFT_waddr; bank_ptr=0; valid=0.
- State FILL:
  - in_ready=1.
  - Transfer = in_valid & in_ready at edge N.
  - At N+1: write has exactly one bit set, at index bank_ptr; din=in_data; valid[bank_ptr] is set; bank_ptr increments.
  - write is 0 in every cycle without a transfer. Write latency is 1 cycle.
  - A transfer with in_last=1, or a transfer into bank PFT_bank-1 (group full), moves the state to HOLD at N+1. in_ready drops at N+1.
  - in_last with in_valid=0 is ignored.
  - start is ignored in FILL.
- State HOLD:
  - in_ready=0; write=0.
  - done rises at N+2, one cycle after the final write strobe, and stays high.
  - valid and PFT_waddr are held.
  - release=1 → IDLE next cycle; valid, done and bank_ptr are cleared.
  - start is ignored in HOLD, including when it coincides with release; release wins.
- release outside HOLD is ignored.
- Wrap-around: the bank pointer never wraps inside a group. Bank PFT_bank-1 always terminates the group, whether or not in_last is set.
- Valid mask: always contiguous from bit 0, with popcount equal to the vectors written. Unwritten banks stay 0, so the PFT substitutes its pad value for them.
- PFT_waddr changes only when start is accepted in IDLE.

Optional Feature:
- Macro PFT_LOADER_CNT_EN.
- Defined: adds output port fill_cnt, width $clog2(PFT_bank)+1.
  - Reset value 0.
  - Increments with each write strobe.
  - Holds its value through HOLD and clears on release.
  - Reads PFT_bank when the group is full.
- Undefined: no port and no counter logic; bank_ptr alone tracks the fill position.

Test Plan:
1. Reset, start with base_addr=5, then 3 vectors A/B/C, in_last on C:
   - write=0x1, 0x2, 0x4 on consecutive cycles, PFT_waddr=5.
   - valid ends at 0x7.
   - done=1 two cycles after C is accepted; in_ready=0 while done=1.
2. Full group: 32 transfers, in_last never asserted:
   - write[31] pulses; valid=0xFFFFFFFF.
   - HOLD is entered, in_ready=0, done=1.
   - A 33rd in_valid is not accepted.
3. Bubbles: in_valid toggles 1,0,1,0 with data X,-,Y:
   - write=0x1, 0, 0x2.
   - No write strobe in bubble cycles.
   - din=X, then din=Y.
4. Simultaneous start and release in HOLD:
   - Next cycle: IDLE, valid=0, done=0.
   - PFT_waddr unchanged (the start is dropped).
   - A following start with base_addr=9 gives PFT_waddr=9.
5. rst_n pulled low in FILL after 2 writes:
   - All outputs 0 immediately, without waiting for a clock edge.
   - After rst_n rises, the loader stays in IDLE with in_ready=0 until start.
6. With PFT_LOADER_CNT_EN defined:
   - fill_cnt=3 after test 1 and 32 after test 2.
   - fill_cnt=0 one cycle after release.
